// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// EXE-stage resolution/update, mispredict flush request and hit/miss statistics.
module branch_predictor #(
  parameter int unsigned IDX_BITS  = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_pc,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic [31:0]          next_pc,
  input  logic                 res_valid,
  input  logic [31:0]          res_pc,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  input  logic                 res_pred_taken,
  input  logic [31:0]          res_pred_target,
  output logic                 predict_wrong,
  output logic [31:0]          fix_pc,
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = 30 - IDX_BITS;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [29:0]      tgt_q   [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_hit;
  logic [IDX_BITS-1:0] res_idx;
  logic [TAG_W-1:0]    res_tag;
  logic                res_hit;

  // Lookup reads only the registered table, so a same-index update is not visible until next cycle.
  always_comb begin
    lk_idx      = if_pc[IDX_BITS+1:2];
    lk_tag      = if_pc[31:IDX_BITS+2];
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && ctr_q[lk_idx][1];
    pred_target = if_pc + 32'd4;
    if (pred_taken) begin
      pred_target = {tgt_q[lk_idx], 2'b00};
    end
  end

  always_comb begin
    res_idx       = res_pc[IDX_BITS+1:2];
    res_tag       = res_pc[31:IDX_BITS+2];
    res_hit       = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    predict_wrong = res_valid &&
                    ((res_taken != res_pred_taken) ||
                     (res_taken && (res_target != res_pred_target)));
    fix_pc        = res_taken ? res_target : (res_pc + 32'd4);
    next_pc       = predict_wrong ? fix_pc : pred_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
        tgt_q[i]   <= '0;
      end
    end else if (res_valid) begin
      if (res_hit) begin
        if (res_taken) begin
          if (ctr_q[res_idx] != 2'b11) begin
            ctr_q[res_idx] <= ctr_q[res_idx] + 2'd1;
          end
          tgt_q[res_idx] <= res_target[31:2];
        end else if (ctr_q[res_idx] != 2'b00) begin
          ctr_q[res_idx] <= ctr_q[res_idx] - 2'd1;
        end
      end else if (res_taken) begin
        // Taken miss allocates (or evicts an alias) as weakly taken.
        valid_q[res_idx] <= 1'b1;
        tag_q[res_idx]   <= res_tag;
        ctr_q[res_idx]   <= 2'b10;
        tgt_q[res_idx]   <= res_target[31:2];
      end
    end
  end

  // Saturating statistics; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (stat_clr) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (res_valid && (branch_cnt != {CNT_WIDTH{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      end
      if (predict_wrong && (miss_cnt != {CNT_WIDTH{1'b1}})) begin
        miss_cnt <= miss_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
